// File: rtl/rvc_asap_dmem_arb.sv
// Round-robin arbiter sharing the single-port data memory between the core (C) and an external port (X).
// Grants are combinational; read data returns one cycle after the grant to the requester that issued the read.
module rvc_asap_dmem_arb #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              Clock,
   input  logic              Rst,
   input  logic              CReq,
   input  logic              CWr,
   input  logic [ADDR_W-1:0] CAddr,
   input  logic [31:0]       CWrData,
   input  logic [3:0]        CByteEn,
   input  logic              XReq,
   input  logic              XWr,
   input  logic [ADDR_W-1:0] XAddr,
   input  logic [31:0]       XWrData,
   input  logic [3:0]        XByteEn,
   output logic              CGnt,
   output logic              XGnt,
   output logic              CRdValid,
   output logic              XRdValid,
   output logic [31:0]       CRdData,
   output logic [31:0]       XRdData,
   output logic              MemEn,
   output logic              MemWr,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemWrData,
   output logic [3:0]        MemByteEn,
   input  logic [31:0]       MemRdData,
   output logic [CNT_W-1:0]  CGntCnt,
   output logic [CNT_W-1:0]  XGntCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             last_gnt_q, last_gnt_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_owner_q, rd_owner_d;
   logic [CNT_W-1:0] c_cnt_q, c_cnt_d;
   logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
   logic             c_gnt, x_gnt;

   // On a tie the requester that did not win last time goes first (last_gnt_q: 0 = C, 1 = X).
   always_comb begin
      c_gnt = CReq & (~XReq | last_gnt_q);
      x_gnt = XReq & (~CReq | ~last_gnt_q);
   end

   always_comb begin
      MemWr     = 1'b0;
      MemAddr   = '0;
      MemWrData = '0;
      MemByteEn = '0;
      if (c_gnt) begin
         MemWr     = CWr;
         MemAddr   = CAddr;
         MemWrData = CWrData;
         MemByteEn = CByteEn;
      end else if (x_gnt) begin
         MemWr     = XWr;
         MemAddr   = XAddr;
         MemWrData = XWrData;
         MemByteEn = XByteEn;
      end
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      rd_owner_d = rd_owner_q;
      if (c_gnt) begin
         last_gnt_d = 1'b0;
      end else if (x_gnt) begin
         last_gnt_d = 1'b1;
      end
      rd_pend_d = (c_gnt | x_gnt) & ~MemWr;
      if (rd_pend_d) begin
         rd_owner_d = x_gnt;
      end
      c_cnt_d = (c_gnt && (c_cnt_q != '1)) ? c_cnt_q + CNT_ONE : c_cnt_q;
      x_cnt_d = (x_gnt && (x_cnt_q != '1)) ? x_cnt_q + CNT_ONE : x_cnt_q;
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         last_gnt_q <= 1'b1;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
         c_cnt_q    <= '0;
         x_cnt_q    <= '0;
      end else begin
         last_gnt_q <= last_gnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         c_cnt_q    <= c_cnt_d;
         x_cnt_q    <= x_cnt_d;
      end
   end

   assign CGnt     = c_gnt;
   assign XGnt     = x_gnt;
   assign MemEn    = c_gnt | x_gnt;
   assign CRdValid = rd_pend_q & ~rd_owner_q;
   assign XRdValid = rd_pend_q & rd_owner_q;
   assign CRdData  = CRdValid ? MemRdData : '0;
   assign XRdData  = XRdValid ? MemRdData : '0;
   assign CGntCnt  = c_cnt_q;
   assign XGntCnt  = x_cnt_q;

endmodule

// File: doc/rvc_asap_dmem_arb.md
# rvc_asap_dmem_arb

Two-requester arbiter that shares the single-port data memory between the rvc_asap core data port (C) and an external loader/debug port (X). Grants one access per cycle to one requester, drives the memory command, and routes the one-cycle-latency read data back to the requester that issued the read. It sits between the core and D_MEM, so the bench and debug logic can access data memory through a real port while the core runs.

## Interface
- ADDR_W, 16, byte address width of the data memory port
- CNT_W, 16, width of each saturating grant counter
- Clock  in  1  core clock
- Rst  in  1  synchronous, active-high reset
- CReq / XReq  in  1  access request from core / external port
- CWr / XWr  in  1  1 = write, 0 = read
- CAddr / XAddr  in  ADDR_W  byte address
- CWrData / XWrData  in  32  write data
- CByteEn / XByteEn  in  4  write byte enables
- CGnt / XGnt  out  1  request accepted this cycle (combinational)
- CRdValid / XRdValid  out  1  read data valid for that requester
- CRdData / XRdData  out  32  read data; meaningful only when the matching RdValid is 1
- MemEn  out  1  memory access this cycle
- MemWr  out  1  write strobe
- MemAddr  out  ADDR_W  memory address
- MemWrData  out  32  memory write data
- MemByteEn  out  4  memory byte enables
- MemRdData  in  32  memory read data; valid one cycle after a read command
- CGntCnt / XGntCnt  out  CNT_W  saturating count of grants since reset

## Operation
- State: LastGnt (1 bit: 0 = C, 1 = X), RdPend (1 bit), RdOwner (1 bit), two grant counters.
- Arbitration each cycle:
  - Only CReq: grant C.
  - Only XReq: grant X.
  - Both: grant the requester not equal to LastGnt (round-robin).
  - Neither: no grant; MemEn = 0.
- On any grant, LastGnt <= granted requester. With no grant, LastGnt holds.
- Memory command:
  - MemEn = CGnt | XGnt.
  - MemWr, MemAddr, MemWrData and MemByteEn come from the granted requester.
  - With no grant, MemWr = 0 and the other command fields are 0.
- Requester handshake:
  - The requester holds Req and its fields stable until it sees Gnt.
  - A request that is not granted is retried by the requester, not queued.
- Read return:
  - A granted read sets RdPend <= 1 and RdOwner <= granted requester.
  - Any other cycle sets RdPend <= 0.
  - CRdValid = RdPend & (RdOwner == C); XRdValid = RdPend & (RdOwner == X).
  - The RdData of the owning requester is MemRdData; the non-owning RdData is 0.
- Writes produce no RdValid.
- Grant counters:
  - Each grant increments the counter of the granted requester.
  - A counter holds at 2^CNT_W-1 instead of wrapping.
- Reset (synchronous) sets:
  - LastGnt <= 1, so C wins the first tie.
  - RdPend <= 0, RdOwner <= 0.
  - Counters <= 0.
- Reset mid-operation: a read granted in the cycle Rst is sampled high is dropped, and no RdValid follows it.

## Timing
- Grant latency is 0 cycles: Gnt and the Mem* command appear in the same cycle as Req.
- Read latency is 1 cycle: RdValid and RdData appear the cycle after Gnt.
- Back-to-back reads are fully pipelined, one per cycle. A read by one requester followed by a read by the other in the next cycle returns to each requester in order.
- Under sustained contention each requester gets exactly 50% of cycles, alternating C, X, C, X.
- Reset values:
  - All Gnt and RdValid outputs are 0.
  - MemEn = 0 and MemWr = 0.
  - All data outputs are 0.
  - Counters are 0.
- Outputs are valid in the first cycle after Rst deasserts.

## Test plan
- Reset, then CReq and XReq both held high for 4 cycles: grants go C, X, C, X; CGntCnt = 2 and XGntCnt = 2.
- X writes 0xDEADBEEF to 0x0100 with ByteEn = 0xF, then C reads 0x0100 in the next cycle: CRdValid = 1 one cycle after CGnt, CRdData = 0xDEADBEEF, XRdValid stays 0.
- C reads 0x0010 (memory holds 0x11111111) and X reads 0x0020 (memory holds 0x22222222) in consecutive cycles: CRdValid is 1 in cycle t+1 with 0x11111111, and XRdValid is 1 in cycle t+2 with 0x22222222.
- Only XReq high for 3 cycles: XGnt is 1 every cycle and CGnt stays 0. Then both request in the next cycle: C is granted, because LastGnt = X.
- C read granted in the same cycle that Rst = 1: no CRdValid in the next cycle, and all outputs are at their reset values.
- CNT_W = 4, CReq held high for 20 cycles: CGntCnt saturates at 15 and stays at 15.
